// File: rtl/counter_pkg.sv
// Shared types and default constants for the counter crossing scheduler.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 200;

endpackage

// File: rtl/counter_sync_2ff.sv
// Two-flop level synchronizer from the crossing library; resets to 0.
module counter_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Metastability filter chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/counter_sync_arb.sv
// Round-robin scheduler sharing one req/ack crossing among saturating
// per-channel event counters.
module counter_sync_arb
    import counter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [NUM_REQ-1:0]         i_evt,
    input  logic                       i_sync_ack,
    input  logic                       i_err_clr,
    output logic                       o_sync_req,
    output logic [$clog2(NUM_REQ)-1:0] o_sync_id,
    output logic [CNT_W-1:0]           o_sync_data,
    output logic                       o_done,
    output logic                       o_err,
    output logic [NUM_REQ-1:0]         o_ovf,
    output logic                       o_busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e               state_r, state_nxt_s;
    logic [ID_W-1:0]      ptr_r;
    logic [TMR_W-1:0]     timer_r;
    logic [CNT_W-1:0]     cnt_r [NUM_REQ];
    logic [NUM_REQ-1:0]   ovf_r;
    logic [NUM_REQ-1:0]   pend_s;
    logic                 req_r, done_r, err_r, busy_r;
    logic [ID_W-1:0]      id_r;
    logic [CNT_W-1:0]     data_r;
    logic                 ack_s;
    logic [ID_W:0]        pick_s;
    logic [ID_W-1:0]      pick_id_s;
    logic                 grant_s, xfer_ok_s, timeout_s;

    // MSB = found; first pending channel strictly after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] pend,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (pend[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    counter_sync_2ff u_ack_sync (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .d     (i_sync_ack),
        .q     (ack_s)
    );

    // Non-zero flags feeding the arbiter
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_s[i] = (cnt_r[i] != '0);
        end
    end

    assign pick_s    = rr_pick(pend_s, ptr_r);
    assign pick_id_s = pick_s[ID_W-1:0];

    // Handshake next-state and event decode
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        xfer_ok_s   = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_s[ID_W]) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    xfer_ok_s   = 1'b1;
                    state_nxt_s = ST_REL;
                end else if (timer_r == TMR_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_REL;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_REL: begin
                if (!ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, pointer, timer and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r <= ST_IDLE;
            ptr_r   <= ID_W'(NUM_REQ - 1);
            timer_r <= '0;
            req_r   <= 1'b0;
            id_r    <= '0;
            data_r  <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= xfer_ok_s;
            if (grant_s) begin
                id_r    <= pick_id_s;
                data_r  <= cnt_r[pick_id_s];
                req_r   <= 1'b1;
                ptr_r   <= pick_id_s;
                timer_r <= '0;
            end else if (xfer_ok_s || timeout_s) begin
                req_r   <= 1'b0;
            end else if (state_r == ST_REQ) begin
                timer_r <= timer_r + TMR_W'(1);
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else if (i_err_clr) begin
                err_r <= 1'b0;
            end
        end
    end

    // Saturating counters; the granted channel restarts from its capture-cycle event
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= '0;
            end
            ovf_r <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_s && (pick_id_s == ID_W'(i))) begin
                    cnt_r[i] <= i_evt[i] ? CNT_W'(1) : '0;
                end else if (i_evt[i]) begin
                    if (cnt_r[i] == CNT_MAX) begin
                        ovf_r[i] <= 1'b1;
                    end else begin
                        cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_sync_req  = req_r;
    assign o_sync_id   = id_r;
    assign o_sync_data = data_r;
    assign o_done      = done_r;
    assign o_err       = err_r;
    assign o_ovf       = ovf_r;
    assign o_busy      = busy_r;

endmodule
